avalon_csr_bank: RTL

AVALON_CSR_BANK -- requirements
Module: avalon_csr_bank

---
 rtl/avs_csr_pkg.sv | 29 ++
 rtl/avs_sync_2ff.sv | 26 ++
 rtl/avalon_csr_bank.sv | 132 +++++++++++++
 3 files changed

// File: rtl/avs_csr_pkg.sv
// Shared address map and lane helpers for the Avalon-MM CSR bank.
// Constants describe the default map; the functions derive it for any parameter set.
package avs_csr_pkg;

  localparam int unsigned DEF_DATA_W   = 32;
  localparam int unsigned DEF_N_RW     = 5;
  localparam int unsigned DEF_N_RO     = 3;
  localparam int unsigned RO_BASE      = DEF_N_RW;
  localparam int unsigned IRQ_STAT_OFS = RO_BASE + DEF_N_RO;
  localparam int unsigned IRQ_MASK_OFS = IRQ_STAT_OFS + 1;
  localparam int unsigned BYTE_LANES   = DEF_DATA_W / 8;

  function automatic int unsigned ro_base_f(input int unsigned n_rw);
    return n_rw;
  endfunction

  function automatic int unsigned irq_stat_ofs_f(input int unsigned n_rw, input int unsigned n_ro);
    return n_rw + n_ro;
  endfunction

  function automatic int unsigned irq_mask_ofs_f(input int unsigned n_rw, input int unsigned n_ro);
    return n_rw + n_ro + 1;
  endfunction

  function automatic int unsigned byte_lanes_f(input int unsigned data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/avs_sync_2ff.sv
// Two-flop synchronizer for quasi-static status bits crossing into the bus clock.
module avs_sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/avalon_csr_bank.sv
// Avalon-MM CSR bank: RW control regs, synchronized RO status, go strobe, optional IRQ.
// Define AVS_CSR_IRQ_EN to build IRQ_STAT/IRQ_MASK and the irq output.
module avalon_csr_bank
  import avs_csr_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned N_RW      = 5,
  parameter int unsigned N_RO      = 3,
  parameter int unsigned PULSE_IDX = 3,
  parameter int unsigned N_IRQ     = 4
) (
  input  logic                   avalon_clk,
  input  logic                   reset_n,
  input  logic                   chipselect,
  input  logic [ADDR_W-1:0]      address,
  input  logic                   write,
  input  logic [DATA_W-1:0]      writedata,
  input  logic [DATA_W/8-1:0]    byteenable,
  input  logic                   read,
  output logic [DATA_W-1:0]      readdata,
  output logic                   readdatavalid,
  output logic [N_RW*DATA_W-1:0] rw_q,
  input  logic [N_RO*DATA_W-1:0] ro_d,
  output logic                   go_pulse,
  input  logic [N_IRQ-1:0]       irq_src,
  output logic                   irq
);

  localparam int unsigned BE_W       = byte_lanes_f(DATA_W);
  localparam int unsigned RO_BASE_A  = ro_base_f(N_RW);
  localparam int unsigned IRQ_STAT_A = irq_stat_ofs_f(N_RW, N_RO);
  localparam int unsigned IRQ_MASK_A = irq_mask_ofs_f(N_RW, N_RO);

  logic [DATA_W-1:0]      r_rw [N_RW];
  logic [N_RO*DATA_W-1:0] w_ro_sync;
  logic [DATA_W-1:0]      w_be_mask;
  logic [DATA_W-1:0]      w_rd_data;
  logic [DATA_W-1:0]      r_readdata;
  logic                   r_readdatavalid;
  logic                   r_go;
  logic                   w_wr;
  logic                   w_rd;

  assign w_wr = chipselect & write;
  assign w_rd = chipselect & read;

  avs_sync_2ff #(.WIDTH(N_RO*DATA_W)) u_ro_sync (
    .clk   (avalon_clk),
    .rst_n (reset_n),
    .i_d   (ro_d),
    .o_q   (w_ro_sync)
  );

  always_comb begin
    w_be_mask = '0;
    for (int k = 0; k < BE_W; k++) w_be_mask[k*8 +: 8] = {8{byteenable[k]}};
  end

  always_ff @(posedge avalon_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_RW; i++) r_rw[i] <= '0;
    end else if (w_wr) begin
      for (int i = 0; i < N_RW; i++)
        if (address == ADDR_W'(i)) r_rw[i] <= (r_rw[i] & ~w_be_mask) | (writedata & w_be_mask);
    end
  end

  always_comb begin
    rw_q = '0;
    for (int i = 0; i < N_RW; i++) rw_q[i*DATA_W +: DATA_W] = r_rw[i];
  end

`ifdef AVS_CSR_IRQ_EN
  logic [N_IRQ-1:0] r_irq_stat;
  logic [N_IRQ-1:0] r_irq_mask;
  logic [N_IRQ-1:0] w_w1c;
  logic             r_irq;

  assign w_w1c = (w_wr && address == ADDR_W'(IRQ_STAT_A)) ? N_IRQ'(writedata & w_be_mask) : '0;

  // A source held high during a W1C keeps its bit set.
  always_ff @(posedge avalon_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irq_stat <= '0;
      r_irq_mask <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_irq_stat <= (r_irq_stat & ~w_w1c) | irq_src;
      if (w_wr && address == ADDR_W'(IRQ_MASK_A))
        r_irq_mask <= (r_irq_mask & ~N_IRQ'(w_be_mask)) | N_IRQ'(writedata & w_be_mask);
      r_irq <= |(r_irq_stat & r_irq_mask);
    end
  end

  assign irq = r_irq;
`else
  logic w_unused_irq_src;
  assign w_unused_irq_src = ^irq_src;
  assign irq = 1'b0;
`endif

  // Read mux sees pre-write state, so same-cycle read/write returns the old value.
  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < N_RW; i++)
      if (address == ADDR_W'(i)) w_rd_data = r_rw[i];
    for (int i = 0; i < N_RO; i++)
      if (address == ADDR_W'(RO_BASE_A + i)) w_rd_data = w_ro_sync[i*DATA_W +: DATA_W];
`ifdef AVS_CSR_IRQ_EN
    if (address == ADDR_W'(IRQ_STAT_A)) w_rd_data = DATA_W'(r_irq_stat);
    if (address == ADDR_W'(IRQ_MASK_A)) w_rd_data = DATA_W'(r_irq_mask);
`endif
  end

  always_ff @(posedge avalon_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_readdata      <= '0;
      r_readdatavalid <= 1'b0;
      r_go            <= 1'b0;
    end else begin
      r_readdatavalid <= w_rd;
      if (w_rd) r_readdata <= w_rd_data;
      r_go <= w_wr && (address == ADDR_W'(PULSE_IDX));
    end
  end

  assign readdata      = r_readdata;
  assign readdatavalid = r_readdatavalid;
  assign go_pulse      = r_go;

endmodule
